// File: rtl/multi_debouncer_if.sv
// Raw-input / debounced-output bundle for multi_debouncer.
// The master drives Signal; the slave (the debouncer) drives the rest.
interface multi_debouncer_if #(
  parameter int CHANNELS = 5
) ();
  logic [CHANNELS-1:0] Signal;
  logic [CHANNELS-1:0] Level;
  logic [CHANNELS-1:0] Pressed;
  logic [CHANNELS-1:0] Released;
  logic                Tick;

  modport master (
    output Signal,
    input  Level,
    input  Pressed,
    input  Released,
    input  Tick
  );

  modport slave (
    input  Signal,
    output Level,
    output Pressed,
    output Released,
    output Tick
  );
endinterface

// File: rtl/multi_debouncer.sv
// N-channel debouncer with Pressed/Released strobes and a shared sample-tick prescaler.
// Optional auto-repeat on held channels is built when AUTOREPEAT_EN is defined.
module multi_debouncer #(
  parameter int CHANNELS       = 5,
  parameter int TICK_PERIOD    = 40000,
  parameter int STABLE_SAMPLES = 4,
  parameter int REPEAT_DELAY   = 50,
  parameter int REPEAT_RATE    = 10
) (
  input logic               Clock,
  input logic               ResetN,
  multi_debouncer_if.slave  bus
);

  localparam int PW = $clog2(TICK_PERIOD);
  localparam int CW = $clog2(STABLE_SAMPLES + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_PERIOD - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_SAMPLES - 1);

  if (CHANNELS < 1 || TICK_PERIOD < 2 || STABLE_SAMPLES < 1 ||
      REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_check
    $error("multi_debouncer: parameter out of range");
  end

  logic [PW-1:0]       r_presc;
  logic [PW-1:0]       w_presc_next;
  logic                r_tick;

  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CW-1:0]       r_cnt      [CHANNELS];
  logic [CW-1:0]       w_cnt_next [CHANNELS];
  logic [CHANNELS-1:0] r_level;
  logic [CHANNELS-1:0] w_level_next;
  logic [CHANNELS-1:0] w_accept;
  logic [CHANNELS-1:0] r_level_prev;
  logic [CHANNELS-1:0] r_pressed;
  logic [CHANNELS-1:0] r_released;
  logic [CHANNELS-1:0] w_rep_fire;

  // Tick is registered one cycle ahead so it lines up with count == TICK_PERIOD-1.
  always_comb begin
    w_presc_next = (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else begin
      r_presc <= w_presc_next;
      r_tick  <= (w_presc_next == PRESC_LAST);
    end
  end

  always_comb begin
    w_accept     = '0;
    w_level_next = r_level;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_cnt_next[i] = r_cnt[i];
      if (r_tick) begin
        if (r_sync2[i] == r_level[i]) begin
          w_cnt_next[i] = '0;
        end else if (r_cnt[i] == CNT_LAST) begin
          w_accept[i]     = 1'b1;
          w_level_next[i] = r_sync2[i];
          w_cnt_next[i]   = '0;
        end else begin
          w_cnt_next[i] = r_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_level      <= '0;
      r_level_prev <= '0;
      r_pressed    <= '0;
      r_released   <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_sync1      <= bus.Signal;
      r_sync2      <= r_sync1;
      r_level      <= w_level_next;
      r_level_prev <= r_level;
      r_pressed    <= (r_level & ~r_level_prev) | w_rep_fire;
      r_released   <= ~r_level & r_level_prev;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_cnt[i] <= w_cnt_next[i];
      end
    end
  end

`ifdef AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);

  logic [RW-1:0]       r_rep      [CHANNELS];
  logic [RW-1:0]       w_rep_next [CHANNELS];
  logic [CHANNELS-1:0] r_rep_first;
  logic [CHANNELS-1:0] w_first_next;

  // A tick whose sample disagrees with Level (release being qualified) neither
  // counts nor fires, so no repeat can slip out after the button is let go.
  always_comb begin
    w_rep_fire   = '0;
    w_first_next = r_rep_first;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      w_rep_next[i] = r_rep[i];
      if (!r_level[i]) begin
        w_rep_next[i]   = '0;
        w_first_next[i] = 1'b1;
      end else if (r_tick && (r_sync2[i] == r_level[i])) begin
        if (r_rep[i] == (r_rep_first[i] ? DELAY_LAST : RATE_LAST)) begin
          w_rep_fire[i]   = 1'b1;
          w_rep_next[i]   = '0;
          w_first_next[i] = 1'b0;
        end else begin
          w_rep_next[i] = r_rep[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_rep_first <= '1;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_rep[i] <= '0;
      end
    end else begin
      r_rep_first <= w_first_next;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        r_rep[i] <= w_rep_next[i];
      end
    end
  end
`else
  assign w_rep_fire = '0;
`endif

  assign bus.Level    = r_level;
  assign bus.Pressed  = r_pressed;
  assign bus.Released = r_released;
  assign bus.Tick     = r_tick;

endmodule

// File: tb/tb_multi_debouncer.sv
// Directed bench for multi_debouncer: TICK_PERIOD=4, STABLE_SAMPLES=3, 5 channels.
// Expectations for the held-button case depend on AUTOREPEAT_EN.
module tb_multi_debouncer;
  localparam int CH = 5;
  localparam int TP = 4;
`ifdef AUTOREPEAT_EN
  localparam bit AUTOREP = 1'b1;
`else
  localparam bit AUTOREP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  multi_debouncer_if #(.CHANNELS(CH)) dbus ();

  multi_debouncer #(
    .CHANNELS(CH),
    .TICK_PERIOD(TP),
    .STABLE_SAMPLES(3),
    .REPEAT_DELAY(5),
    .REPEAT_RATE(2)
  ) dut (
    .Clock(clk),
    .ResetN(rst_n),
    .bus(dbus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_tick(input string tag);
    int k;
    k = 0;
    step(1);
    while (dbus.Tick !== 1'b1 && k < 2 * TP) begin
      step(1);
      k++;
    end
    chk({tag, "_tick_found"}, 32'(dbus.Tick), 32'h1);
  endtask

  // Aligns to a tick, applies sig, and checks Level/strobes around the 3rd tick.
  task automatic transition(input logic [4:0] sig, input logic [4:0] lvl_before,
                            input logic [4:0] lvl_after, input logic [4:0] ep,
                            input logic [4:0] er, input string tag);
    wait_tick(tag);
    dbus.Signal = sig;
    step(12);
    chk({tag, "_tick3"}, 32'(dbus.Tick), 32'h1);
    chk({tag, "_level_before"}, 32'(dbus.Level), 32'(lvl_before));
    step(1);
    chk({tag, "_level_after"}, 32'(dbus.Level), 32'(lvl_after));
    chk({tag, "_no_early_strobe"}, 32'({dbus.Pressed, dbus.Released}), 32'h0);
    step(1);
    chk({tag, "_pressed"}, 32'(dbus.Pressed), 32'(ep));
    chk({tag, "_released"}, 32'(dbus.Released), 32'(er));
    step(1);
    chk({tag, "_strobe_cleared"}, 32'({dbus.Pressed, dbus.Released}), 32'h0);
  endtask

  initial begin
    logic [4:0] exp_lvl;
    logic [4:0] exp_p;
    logic [4:0] exp_r;
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    dbus.Signal = '1;

    // 1. Reset hold with all inputs high, then tick cadence
    for (int c = 0; c < 20; c++) begin
      step(1);
      chk("reset_hold", 32'({dbus.Level, dbus.Pressed, dbus.Released, dbus.Tick}), 32'h0);
    end
    dbus.Signal = '0;
    rst_n = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step(1);
      chk("tick_cadence", 32'(dbus.Tick), 32'(c % 4 == 3));
      chk("idle_level", 32'(dbus.Level), 32'h0);
    end

    // 2. Clean press and release on ch0
    transition(5'b00001, 5'b00000, 5'b00001, 5'b00001, 5'b00000, "press_ch0");
    transition(5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00001, "release_ch0");

    // 3. Bounce on ch1
    for (int k = 0; k < 10; k++) begin
      dbus.Signal[1] = ~dbus.Signal[1];
      for (int c = 0; c < 4; c++) begin
        step(1);
        chk("bounce_quiet", 32'({dbus.Level, dbus.Pressed, dbus.Released}), 32'h0);
      end
    end
    step(16);
    chk("bounce_level", 32'(dbus.Level), 32'h0);

    // 4. Simultaneous press/release on ch0 and ch4
    transition(5'b10001, 5'b00000, 5'b10001, 5'b10001, 5'b00000, "press_ch0_ch4");
    transition(5'b00000, 5'b10001, 5'b00000, 5'b00000, 5'b10001, "release_ch0_ch4");

    // 5. Reset after two of three qualifying ticks on ch2
    wait_tick("mid_reset");
    dbus.Signal = 5'b00100;
    step(8);
    chk("mid_reset_tick2", 32'(dbus.Tick), 32'h1);
    chk("mid_reset_level_pre", 32'(dbus.Level), 32'h0);
    step(1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_async", 32'({dbus.Level, dbus.Pressed, dbus.Released, dbus.Tick}), 32'h0);
    for (int c = 0; c < 5; c++) begin
      step(1);
      chk("mid_reset_hold", 32'({dbus.Level, dbus.Pressed, dbus.Released, dbus.Tick}), 32'h0);
    end
    rst_n = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      step(1);
      exp_lvl = (c >= 12) ? 5'b00100 : 5'b00000;
      exp_p   = (c == 13) ? 5'b00100 : 5'b00000;
      chk("post_reset_tick", 32'(dbus.Tick), 32'(c % 4 == 3));
      chk("post_reset_level", 32'(dbus.Level), 32'(exp_lvl));
      chk("post_reset_pressed", 32'(dbus.Pressed), 32'(exp_p));
      chk("post_reset_released", 32'(dbus.Released), 32'h0);
    end
    transition(5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00100, "release_ch2");

    // 6. Long hold on ch3, released after the third repeat slot
    wait_tick("hold_ch3");
    dbus.Signal = 5'b01000;
    for (int c = 1; c <= 64; c++) begin
      step(1);
      exp_lvl = (c >= 13 && c <= 60) ? 5'b01000 : 5'b00000;
      exp_p   = (c == 14 || (AUTOREP && (c == 33 || c == 41 || c == 49))) ? 5'b01000 : 5'b00000;
      exp_r   = (c == 62) ? 5'b01000 : 5'b00000;
      chk("hold_level", 32'(dbus.Level), 32'(exp_lvl));
      chk("hold_pressed", 32'(dbus.Pressed), 32'(exp_p));
      chk("hold_released", 32'(dbus.Released), 32'(exp_r));
      if (c == 49) dbus.Signal = 5'b00000;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
